// File: rtl/tis_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tis_pkg : shared TIS grid defaults and the execution-controller state type.
// Rev 1.0
// ---------------------------------------------------------------------------
package tis_pkg;

  localparam int TIS_NCORES = 12;
  localparam int TIS_PCW    = 4;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    RUN   = 3'd2,
    STEP  = 3'd3,
    LOAD  = 3'd4
  } exec_state_t;

endpackage
`default_nettype wire

// File: rtl/tis_pc_select.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tis_pc_select : picks one core's PC out of the flat PC bus and flags a match.
// Rev 1.0
// ---------------------------------------------------------------------------
module tis_pc_select
  import tis_pkg::*;
#(
  parameter int NCORES = TIS_NCORES,
  parameter int PCW    = TIS_PCW
) (
  input  logic [NCORES*PCW-1:0] pc_flat,
  input  logic                  bp_en,
  input  logic [3:0]            bp_core,
  input  logic [PCW-1:0]        bp_pc,
  output logic [PCW-1:0]        sel_pc,
  output logic                  match
);

  logic core_ok;

  always_comb begin
    sel_pc = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (bp_core == 4'(i)) sel_pc = pc_flat[i*PCW +: PCW];
    end
  end

  // Out-of-range core indices can never match.
  assign core_ok = ({28'd0, bp_core} < 32'(NCORES));
  assign match   = bp_en && core_ok && (sel_pc == bp_pc);

endmodule
`default_nettype wire

// File: rtl/tis_exec_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tis_exec_ctl : run/stop/step/clear sequencer with PC breakpoint and loader arbitration.
// Rev 1.0
// ---------------------------------------------------------------------------
module tis_exec_ctl
  import tis_pkg::*;
#(
  parameter int NCORES       = TIS_NCORES,
  parameter int PCW          = TIS_PCW,
  parameter int CYCW         = 16,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_run,
  input  logic                  cmd_stop,
  input  logic                  cmd_step,
  input  logic                  cmd_clear,
  input  logic                  bp_en,
  input  logic [3:0]            bp_core,
  input  logic [PCW-1:0]        bp_pc,
  input  logic [NCORES*PCW-1:0] pc_flat,
  input  logic                  load_req,
  output logic                  load_gnt,
  output logic                  core_en,
  output logic                  core_rst,
  output logic [2:0]            state,
  output logic                  bp_hit,
  output logic [CYCW-1:0]       cycle_count
);

  localparam int CLRW = $clog2(CLEAR_CYCLES + 1);

  exec_state_t     cur_state, nxt_state;
  logic [CLRW-1:0] clr_cnt;
  logic            first_run;
  logic            bp_match;
  logic            bp_stop;
  logic [PCW-1:0]  sel_pc;

  tis_pc_select #(
    .NCORES (NCORES),
    .PCW    (PCW)
  ) u_pc_select (
    .pc_flat (pc_flat),
    .bp_en   (bp_en),
    .bp_core (bp_core),
    .bp_pc   (bp_pc),
    .sel_pc  (sel_pc),
    .match   (bp_match)
  );

  always_comb begin
    nxt_state = cur_state;
    core_en   = 1'b0;
    bp_stop   = 1'b0;
    case (cur_state)
      CLEAR: begin
        if (clr_cnt == CLRW'(1)) nxt_state = IDLE;
      end
      IDLE: begin
        if (cmd_clear)     nxt_state = CLEAR;
        else if (load_req) nxt_state = LOAD;
        else if (cmd_run)  nxt_state = RUN;
        else if (cmd_step) nxt_state = STEP;
      end
      RUN: begin
        // Masked on the first cycle so a resume at the breakpoint PC moves past it.
        core_en = !(bp_match && !first_run);
        if (cmd_clear)     nxt_state = CLEAR;
        else if (cmd_stop) nxt_state = IDLE;
        else if (bp_match && !first_run) begin
          nxt_state = IDLE;
          bp_stop   = 1'b1;
        end
      end
      STEP: begin
        core_en   = !cmd_clear;
        nxt_state = cmd_clear ? CLEAR : IDLE;
      end
      LOAD: begin
        if (!load_req) nxt_state = CLEAR;
      end
      default: nxt_state = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= CLEAR;
      clr_cnt     <= CLRW'(CLEAR_CYCLES);
      first_run   <= 1'b0;
      core_rst    <= 1'b1;
      load_gnt    <= 1'b0;
      bp_hit      <= 1'b0;
      cycle_count <= '0;
    end else begin
      cur_state <= nxt_state;
      core_rst  <= (nxt_state == CLEAR);
      load_gnt  <= (nxt_state == LOAD);
      first_run <= (cur_state == IDLE) && (nxt_state == RUN);

      if ((nxt_state == CLEAR) && (cur_state != CLEAR)) clr_cnt <= CLRW'(CLEAR_CYCLES);
      else if (cur_state == CLEAR)                      clr_cnt <= clr_cnt - CLRW'(1);

      if (nxt_state == CLEAR) bp_hit <= 1'b0;
      else if (bp_stop)       bp_hit <= 1'b1;
      else if ((cur_state == IDLE) && ((nxt_state == RUN) || (nxt_state == STEP)))
        bp_hit <= 1'b0;

      if ((nxt_state == CLEAR) || (cur_state == CLEAR)) cycle_count <= '0;
      else if (core_en && (cycle_count != {CYCW{1'b1}})) cycle_count <= cycle_count + 1'b1;
    end
  end

  assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_tis_exec_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tis_exec_ctl : directed bench for tis_exec_ctl (16-bit and 4-bit counter builds).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_tis_exec_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_run, cmd_stop, cmd_step, cmd_clear;
  logic        bp_en;
  logic [3:0]  bp_core;
  logic [3:0]  bp_pc;
  logic        load_req;
  logic [47:0] pc_flat;
  logic [3:0]  pc1;

  logic        load_gnt, core_en, core_rst, bp_hit;
  logic [2:0]  state;
  logic [15:0] cycle_count;

  logic        load_gnt4, core_en4, core_rst4, bp_hit4;
  logic [2:0]  state4;
  logic [3:0]  cycle_count4;

  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  assign pc_flat = {40'd0, pc1, 4'd0};

  // Core 1 model: PC advances on each enabled cycle, cleared by core reset.
  always @(posedge clk) begin
    if (core_rst === 1'b1)     pc1 <= 4'd0;
    else if (core_en === 1'b1) pc1 <= pc1 + 4'd1;
  end

  tis_exec_ctl #(.NCORES(12), .PCW(4), .CYCW(16), .CLEAR_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cmd_run(cmd_run), .cmd_stop(cmd_stop), .cmd_step(cmd_step),
    .cmd_clear(cmd_clear), .bp_en(bp_en), .bp_core(bp_core), .bp_pc(bp_pc), .pc_flat(pc_flat),
    .load_req(load_req), .load_gnt(load_gnt), .core_en(core_en), .core_rst(core_rst),
    .state(state), .bp_hit(bp_hit), .cycle_count(cycle_count)
  );

  tis_exec_ctl #(.NCORES(12), .PCW(4), .CYCW(4), .CLEAR_CYCLES(2)) dut4 (
    .clk(clk), .rst(rst), .cmd_run(cmd_run), .cmd_stop(cmd_stop), .cmd_step(cmd_step),
    .cmd_clear(cmd_clear), .bp_en(bp_en), .bp_core(bp_core), .bp_pc(bp_pc), .pc_flat(pc_flat),
    .load_req(load_req), .load_gnt(load_gnt4), .core_en(core_en4), .core_rst(core_rst4),
    .state(state4), .bp_hit(bp_hit4), .cycle_count(cycle_count4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // 0=run 1=stop 2=step 3=clear; one-cycle pulse launched from a negedge.
  task automatic cmd(input int which);
    cmd_run   = (which == 0);
    cmd_stop  = (which == 1);
    cmd_step  = (which == 2);
    cmd_clear = (which == 3);
    tick();
    cmd_run = 0; cmd_stop = 0; cmd_step = 0; cmd_clear = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1; cmd_run = 0; cmd_stop = 0; cmd_step = 0; cmd_clear = 0;
    bp_en = 0; bp_core = 4'd0; bp_pc = 4'd0; load_req = 0;
    @(negedge clk);
    repeat (3) tick();

    // Reset state
    check("rst_state", 32'(state), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_load_gnt", 32'(load_gnt), 32'd0);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);
    check("rst_count", 32'(cycle_count), 32'd0);

    // Release: core_rst held for CLEAR_CYCLES cycles
    rst = 0;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (core_rst === 1'b1) n++;
      tick();
    end
    check("clear_len", 32'(n), 32'd2);
    check("clear_to_idle", 32'(state), 32'd1);
    check("clear_count", 32'(cycle_count), 32'd0);
    check("clear_core_en", 32'(core_en), 32'd0);

    // Stop in IDLE is a no-op
    cmd(1);
    check("idle_stop_noop", 32'(state), 32'd1);

    // Run and stop
    cmd(0);
    check("run_state", 32'(state), 32'd2);
    check("run_core_en", 32'(core_en), 32'd1);
    repeat (10) tick();
    cmd(1);
    check("stop_count", 32'(cycle_count), 32'd11);
    check("stop_state", 32'(state), 32'd1);
    check("stop_core_en", 32'(core_en), 32'd0);

    // Clear then three single steps
    cmd(3);
    check("clr_cmd_state", 32'(state), 32'd0);
    check("clr_cmd_count", 32'(cycle_count), 32'd0);
    repeat (2) tick();
    check("clr_cmd_idle", 32'(state), 32'd1);
    n = 0;
    for (int s = 0; s < 3; s++) begin
      cmd(2);
      if (core_en === 1'b1) n++;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (core_en !== 1'b0) n = n + 10;
      end
    end
    check("step_pulses", 32'(n), 32'd3);
    check("step_count", 32'(cycle_count), 32'd3);

    // Breakpoint on core 1 at PC 5
    bp_en = 1; bp_core = 4'd1; bp_pc = 4'd5;
    cmd(3);
    repeat (2) tick();
    check("bp_pc_cleared", 32'(pc1), 32'd0);
    cmd(0);
    n = 0;
    while (core_en === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("bp_halt_pc", 32'(pc1), 32'd5);
    check("bp_halt_state", 32'(state), 32'd2);
    tick();
    check("bp_idle", 32'(state), 32'd1);
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_count", 32'(cycle_count), 32'd5);
    check("bp_pc_held", 32'(pc1), 32'd5);
    cmd(0);
    check("bp_resume_en", 32'(core_en), 32'd1);
    check("bp_hit_cleared", 32'(bp_hit), 32'd0);
    tick();
    check("bp_resume_pc", 32'(pc1), 32'd6);
    cmd(1);
    bp_en = 0;

    // Load arbitration
    cmd(0);
    load_req = 1;
    repeat (3) tick();
    check("load_run_nogrant", 32'(load_gnt), 32'd0);
    check("load_run_state", 32'(state), 32'd2);
    cmd(1);
    check("load_stop_idle", 32'(state), 32'd1);
    tick();
    check("load_gnt", 32'(load_gnt), 32'd1);
    check("load_state", 32'(state), 32'd4);
    check("load_core_en", 32'(core_en), 32'd0);
    cmd(0);
    check("load_run_ignored", 32'(state), 32'd4);
    check("load_gnt_held", 32'(load_gnt), 32'd1);
    load_req = 0;
    tick();
    check("load_rel_state", 32'(state), 32'd0);
    check("load_rel_gnt", 32'(load_gnt), 32'd0);
    check("load_rel_core_rst", 32'(core_rst), 32'd1);
    tick();
    check("load_clear2", 32'(state), 32'd0);
    tick();
    check("load_idle", 32'(state), 32'd1);

    // Clear during step: step suppressed
    cmd_step = 1;
    tick();
    cmd_step = 0;
    cmd_clear = 1;
    #1;
    check("step_clear_en", 32'(core_en), 32'd0);
    @(negedge clk);
    cmd_clear = 0;
    check("step_clear_state", 32'(state), 32'd0);
    repeat (2) tick();

    // Clear and stop together in RUN
    cmd(0);
    repeat (2) tick();
    cmd_clear = 1; cmd_stop = 1;
    tick();
    cmd_clear = 0; cmd_stop = 0;
    check("clr_stop_state", 32'(state), 32'd0);
    check("clr_stop_count", 32'(cycle_count), 32'd0);
    repeat (2) tick();
    check("clr_stop_idle", 32'(state), 32'd1);

    // Saturation: 20 enabled cycles
    cmd(0);
    repeat (19) tick();
    cmd(1);
    check("sat16_count", 32'(cycle_count), 32'd20);
    check("sat4_count", 32'(cycle_count4), 32'd15);
    check("sat4_state", 32'(state4), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
